baud_config_ctrl: RTL and testbench

Runtime baud-rate configuration controller that sits between the host/register interface and baud_rate_generator. It accepts baud-rate change requests through a valid/ready handshake and range-checks them. It computes the clock divisor with a sequential divider, waits until the UART is quiescent, then commits the new baud_rate/divisor atomically while holding the generator. This makes mid-traffic rate changes glitch-free.

---
 rtl/baud_config_ctrl_if.sv | 24 ++
 rtl/baud_config_ctrl.sv | 155 +++++++++++++++
 tb/tb_baud_config_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/baud_config_ctrl_if.sv
// Host-side configuration and status bundle for baud_config_ctrl.
// The master modport belongs to the register/host and UART side; the controller uses slave.
interface baud_config_ctrl_if;
  logic        cfg_valid;
  logic [31:0] cfg_baud;
  logic        cfg_ready;
  logic        uart_idle;
  logic [31:0] baud_rate;
  logic [31:0] divisor;
  logic        gen_hold;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;

  modport master (
    output cfg_valid, cfg_baud, uart_idle,
    input  cfg_ready, baud_rate, divisor, gen_hold, busy, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_baud, uart_idle,
    output cfg_ready, baud_rate, divisor, gen_hold, busy, cfg_done, cfg_err
  );
endinterface

// File: rtl/baud_config_ctrl.sv
// Range-checks baud requests, divides CLK_FREQ over 32 cycles, waits for a quiet UART, then commits.
// Commit lands 34+GUARD_CYCLES cycles after accept; cfg_ready stays low while busy, with no request queue.
module baud_config_ctrl #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned MIN_BAUD     = 1200,
  parameter int unsigned MAX_BAUD     = 5000000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  baud_config_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIVIDE,
    S_WAIT_IDLE,
    S_APPLY,
    S_RELEASE
  } state_e;

  localparam logic [31:0] DIVIDEND   = 32'(CLK_FREQ);
  localparam logic [31:0] RST_BAUD   = 32'(DEFAULT_BAUD);
  localparam logic [31:0] RST_DIV    = 32'(CLK_FREQ / DEFAULT_BAUD);
  localparam logic [31:0] LO_BAUD    = 32'(MIN_BAUD);
  localparam logic [31:0] HI_BAUD    = 32'(MAX_BAUD);
  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] baud_q, baud_d;
  logic [31:0] div_q, div_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] idle_cnt_q, idle_cnt_d;

  logic        ready_c, hold_c, done_c, err_c;
  logic [33:0] rem_shift;
  logic        in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cap_q      <= '0;
      baud_q     <= RST_BAUD;
      div_q      <= RST_DIV;
      rem_q      <= '0;
      quo_q      <= '0;
      bit_q      <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      baud_q     <= baud_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      bit_q      <= bit_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    baud_d     = baud_q;
    div_d      = div_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    bit_d      = bit_q;
    idle_cnt_d = idle_cnt_q;
    ready_c    = 1'b0;
    hold_c     = 1'b0;
    done_c     = 1'b0;
    err_c      = 1'b0;

    // Restoring step: bring down the next dividend bit, MSB first.
    rem_shift = {rem_q, DIVIDEND[5'd31 - bit_q]};
    in_range  = (cap_q >= LO_BAUD) && (cap_q <= HI_BAUD);

    unique case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.cfg_valid) begin
          cap_d   = bus.cfg_baud;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!in_range) begin
          err_c   = 1'b1;
          state_d = S_IDLE;
        end else if (cap_q == baud_q) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else begin
          rem_d   = '0;
          quo_d   = '0;
          bit_d   = '0;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (rem_shift >= {2'b00, cap_q}) begin
          rem_d = 33'(rem_shift - {2'b00, cap_q});
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = 33'(rem_shift);
          quo_d = {quo_q[30:0], 1'b0};
        end
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd31) begin
          idle_cnt_d = '0;
          state_d    = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // Any busy cycle restarts the quiet-period count.
        if (!bus.uart_idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == GUARD_LAST) begin
          state_d = S_APPLY;
        end else begin
          idle_cnt_d = idle_cnt_q + 32'd1;
        end
      end
      S_APPLY: begin
        hold_c  = 1'b1;
        baud_d  = cap_q;
        div_d   = quo_q;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        hold_c  = 1'b1;
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cfg_ready = ready_c;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.gen_hold  = hold_c;
  assign bus.cfg_done  = done_c;
  assign bus.cfg_err   = err_c;
  assign bus.baud_rate = baud_q;
  assign bus.divisor   = div_q;

endmodule

// File: tb/tb_baud_config_ctrl.sv
// Directed bench for baud_config_ctrl: per-cycle output logs checked against hand-computed values.
module tb_baud_config_ctrl;
  logic clk;
  logic rst;

  baud_config_ctrl_if bus ();

  baud_config_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  int cyc;
  int idle_mode;
  int pulse_cyc;
  int pulse_baud;
  int rst_cyc;

  logic        hold_log [0:255];
  logic        rdy_log  [0:255];
  logic        busy_log [0:255];
  logic [31:0] div_log  [0:255];
  logic [31:0] baud_log [0:255];

  int hold_first, hold_last, hold_cnt;
  int done_first, done_cnt;
  int err_first, err_cnt;
  int both_cnt;

  int cur_baud;
  int cur_div;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic idle_at(input int c);
    if (idle_mode == 0) return 1'b1;
    return (c > 100) && (c != 111);
  endfunction

  // Caller sits 1 time unit after a rising edge; leaves at cycle 1 after the accepting edge.
  task automatic request(input int baud);
    chk("ready_before_req", 32'(bus.cfg_ready), 32'd1);
    bus.cfg_valid = 1'b1;
    bus.cfg_baud  = 32'(baud);
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    cyc = 1;
  endtask

  // Drives per-cycle stimulus and logs outputs for cycles cyc..last.
  task automatic watch(input int last);
    hold_first = -1; hold_last = -1; hold_cnt = 0;
    done_first = -1; done_cnt  = 0;
    err_first  = -1; err_cnt   = 0;
    both_cnt   = 0;
    while (cyc <= last) begin
      bus.uart_idle = idle_at(cyc);
      bus.cfg_valid = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) bus.cfg_baud = 32'(pulse_baud);
      rst = (cyc == rst_cyc);
      if (cyc < 256) begin
        hold_log[cyc] = bus.gen_hold;
        rdy_log[cyc]  = bus.cfg_ready;
        busy_log[cyc] = bus.busy;
        div_log[cyc]  = bus.divisor;
        baud_log[cyc] = bus.baud_rate;
      end
      if (bus.gen_hold) begin
        if (hold_first < 0) hold_first = cyc;
        hold_last = cyc;
        hold_cnt++;
      end
      if (bus.cfg_done) begin
        if (done_first < 0) done_first = cyc;
        done_cnt++;
      end
      if (bus.cfg_err) begin
        if (err_first < 0) err_first = cyc;
        err_cnt++;
      end
      if (bus.cfg_done && bus.cfg_err) both_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.cfg_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic check_commit(input string tag, input int new_baud, input int new_div,
                              input int done_at);
    chk({tag, "_ready_drop"}, 32'(rdy_log[1]), 32'd0);
    chk({tag, "_busy"},       32'(busy_log[1]), 32'd1);
    chk({tag, "_hold_first"}, 32'(hold_first), 32'(done_at - 1));
    chk({tag, "_hold_last"},  32'(hold_last), 32'(done_at));
    chk({tag, "_hold_cnt"},   32'(hold_cnt), 32'd2);
    chk({tag, "_done_at"},    32'(done_first), 32'(done_at));
    chk({tag, "_done_cnt"},   32'(done_cnt), 32'd1);
    chk({tag, "_err_cnt"},    32'(err_cnt), 32'd0);
    chk({tag, "_both"},       32'(both_cnt), 32'd0);
    chk({tag, "_div_old"},    div_log[done_at - 1], 32'(cur_div));
    chk({tag, "_baud_old"},   baud_log[done_at - 1], 32'(cur_baud));
    chk({tag, "_div_new"},    div_log[done_at], 32'(new_div));
    chk({tag, "_baud_new"},   baud_log[done_at], 32'(new_baud));
    chk({tag, "_ready_back"}, 32'(rdy_log[done_at + 1]), 32'd1);
    cur_baud = new_baud;
    cur_div  = new_div;
  endtask

  int rej_tab [0:4] = '{600, 1199, 5000001, 6000000, 0};

  initial begin
    errs = 0; checks = 0;
    idle_mode = 0; pulse_cyc = -1; pulse_baud = 0; rst_cyc = -1;
    cyc = 0;
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_baud  = '0;
    bus.uart_idle = 1'b1;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_baud",  bus.baud_rate, 32'd9600);
    chk("rst_div",   bus.divisor, 32'd5208);
    chk("rst_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_hold",  32'(bus.gen_hold), 32'd0);
    chk("rst_done",  32'(bus.cfg_done), 32'd0);
    chk("rst_err",   32'(bus.cfg_err), 32'd0);
    cur_baud = 9600;
    cur_div  = 5208;

    // Same rate as current: immediate done, no hold.
    request(9600);
    watch(4);
    chk("same_done_at",  32'(done_first), 32'd1);
    chk("same_done_cnt", 32'(done_cnt), 32'd1);
    chk("same_hold_cnt", 32'(hold_cnt), 32'd0);
    chk("same_err_cnt",  32'(err_cnt), 32'd0);
    chk("same_ready2",   32'(rdy_log[2]), 32'd1);

    request(115200);
    watch(53);
    check_commit("b115200", 115200, 434, 51);

    request(5000000);
    watch(53);
    check_commit("b5m", 5000000, 10, 51);

    // UART busy for 100 cycles, 10 idle, one busy cycle, then idle.
    idle_mode = 1;
    request(1000000);
    watch(132);
    check_commit("b1m", 1000000, 50, 129);
    idle_mode = 0;

    foreach (rej_tab[i]) begin
      request(rej_tab[i]);
      watch(4);
      chk($sformatf("rej%0d_err_at", rej_tab[i]),   32'(err_first), 32'd1);
      chk($sformatf("rej%0d_err_cnt", rej_tab[i]),  32'(err_cnt), 32'd1);
      chk($sformatf("rej%0d_done_cnt", rej_tab[i]), 32'(done_cnt), 32'd0);
      chk($sformatf("rej%0d_hold_cnt", rej_tab[i]), 32'(hold_cnt), 32'd0);
      chk($sformatf("rej%0d_ready2", rej_tab[i]),   32'(rdy_log[2]), 32'd1);
      chk($sformatf("rej%0d_div", rej_tab[i]),      div_log[4], 32'(cur_div));
      chk($sformatf("rej%0d_baud", rej_tab[i]),     baud_log[4], 32'(cur_baud));
    end

    request(1200);
    watch(53);
    check_commit("b1200", 1200, 41666, 51);

    // Ignored pulse during DIVIDE, then reset mid-DIVIDE.
    request(19200);
    pulse_cyc = 5; pulse_baud = 38400; rst_cyc = 10;
    watch(60);
    pulse_cyc = -1; rst_cyc = -1;
    chk("abort_ready_at_pulse", 32'(rdy_log[5]), 32'd0);
    chk("abort_busy_at_pulse",  32'(busy_log[5]), 32'd1);
    chk("abort_done_cnt",       32'(done_cnt), 32'd0);
    chk("abort_hold_cnt",       32'(hold_cnt), 32'd0);
    chk("abort_baud",           baud_log[11], 32'd9600);
    chk("abort_div",            div_log[11], 32'd5208);
    chk("abort_ready",          32'(rdy_log[11]), 32'd1);
    chk("abort_busy",           32'(busy_log[11]), 32'd0);
    chk("abort_baud_late",      baud_log[60], 32'd9600);
    cur_baud = 9600;
    cur_div  = 5208;

    // Retry with another ignored pulse; no queued request afterwards.
    request(19200);
    pulse_cyc = 20; pulse_baud = 38400;
    watch(56);
    pulse_cyc = -1;
    check_commit("b19200", 19200, 2604, 51);
    chk("retry_ready_at_pulse", 32'(rdy_log[20]), 32'd0);
    chk("retry_busy_after",     32'(busy_log[53]), 32'd0);
    chk("retry_baud_after",     baud_log[56], 32'd19200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
